muldiv_ctrl: RTL



---
 rtl/muldiv_ctrl_pkg.sv | 14 +
 rtl/muldiv_alu.sv | 29 ++
 rtl/muldiv_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: op/state encodings and default latencies for the HI/LO multiply-divide unit
package muldiv_ctrl_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_e;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/muldiv_alu.sv
// muldiv_alu: combinational 32x32 multiply and divide producing a HI/LO pair
module muldiv_alu
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);
  logic        sgn, is_div, na, nb;
  logic [63:0] prod;
  logic [31:0] ua, ub, dv, q, r;
  assign sgn    = (op == MD_MULT) || (op == MD_DIV);
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign na     = sgn & a[31];
  assign nb     = sgn & b[31];
  assign prod   = {{32{na}}, a} * {{32{nb}}, b};
  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing
  assign ua       = na ? -a : a;
  assign ub       = nb ? -b : b;
  assign div_zero = is_div && (b == 32'd0);
  assign dv       = (b == 32'd0) ? 32'd1 : ub;
  assign q        = ua / dv;
  assign r        = ua % dv;
  assign res_lo   = is_div ? ((na ^ nb) ? -q : q) : prod[31:0];
  assign res_hi   = is_div ? (na ? -r : r) : prod[63:32];
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle HI/LO sequencer with busy/done handshake for the E stage
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  md_state_e   state;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi, pend_lo, res_hi, res_lo;
  logic        pend_wr, div_zero;
  muldiv_alu u_alu (
    .op      (op),
    .a       (a),
    .b       (b),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .div_zero(div_zero)
  );
  assign busy = start | (state != IDLE);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start)
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state   <= op[1] ? DIV : MUL;
              cnt     <= op[1] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_wr <= !div_zero;
            end
            MD_MTHI: hi <= a;
            MD_MTLO: lo <= a;
            default: ;
          endcase
      end else if (cnt == '0) begin
        // Divide by zero keeps the timing and done pulse but leaves HI/LO untouched
        if (pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
        done  <= 1'b1;
        state <= IDLE;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule
